// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and frame helper for the PS/2 host transmitter
//
// Purpose : FSM state encodings, frame geometry and common device command bytes
//           used by ps2_host_tx and its line synchronizer.
// Ports   : none (package).
package ps2_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_ACK  = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  // Full frame on the wire is start + 8 data + parity + stop; the host only
  // shifts the 10 bits that follow the start bit.
  localparam int PS2_FRAME_BITS   = 11;
  localparam int PS2_PAYLOAD_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // {stop, odd parity, data}, transmitted LSB first.
  function automatic logic [PS2_PAYLOAD_BITS-1:0] build_payload(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 line synchronizer, optional glitch filter, falling-edge strobe
//
// Purpose : bring one raw open-drain PS/2 line into the clk domain.
// Config  : PS2_TX_GLITCH_FILTER_EN - when defined, the synchronized level must
//           hold for 4 consecutive samples before the filtered level follows it.
// Ports   : clk, rst   - system clock, asynchronous active-high reset
//           line_in    - raw PS/2 line
//           level      - synchronized (optionally filtered) line level
//           fe         - one-cycle strobe on a falling edge of level
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;
  logic                   level_cur;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Chain resets to the released (high) level so leaving reset never looks
  // like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [1:0] run_q, run_d;

  // run counts consecutive samples that disagree with the filtered level;
  // the fourth one in a row flips it.
  always_comb begin
    filt_d = filt_q;
    run_d  = 2'd0;
    if (sync_out != filt_q) begin
      if (run_q == 2'd3) begin
        filt_d = sync_out;
      end else begin
        run_d = run_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      run_q  <= 2'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign level_cur = filt_q;
`else
  assign level_cur = sync_out;
`endif

  always_comb begin
    prev_d = level_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign level = level_cur;
  assign fe    = prev_q & ~level_cur;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose : inhibit the PS/2 clock, request-to-send, shift start/8 data/odd
//           parity/stop on device clock falling edges, check the device ACK.
// Config  : PS2_TX_GLITCH_FILTER_EN - enables the 4-sample clock glitch filter
//           inside ps2_line_sync.
// Ports   : clk, rst              - system clock, asynchronous active-high reset
//           tx_data, tx_start     - command byte and one-cycle send request
//           tx_busy               - transfer in progress (through the result pulse)
//           tx_done, tx_err       - one-cycle result pulses
//           ps2_clk_in/data_in    - raw PS/2 lines
//           ps2_clk_oe/data_oe    - 1 pulls the corresponding line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_END  = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [3:0]                  bit_idx_q, bit_idx_d;
  logic [PS2_PAYLOAD_BITS-1:0] frame_q, frame_d;
  logic                        clk_oe_q, clk_oe_d;
  logic                        data_oe_q, data_oe_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic clk_lvl, clk_fe, data_lvl, data_fe_unused;
  logic timed_out;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_lvl),
    .fe      (clk_fe)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data_in),
    .level   (data_lvl),
    .fe      (data_fe_unused)
  );

  // A falling edge in the same cycle as the final count wins: the device is
  // still alive, so the watchdog restarts instead of aborting.
  assign timed_out = !clk_fe && (cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d    = 1'b0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        // busy_q is still high during the result pulse cycle; no new request
        // is taken until it has dropped.
        if (tx_start && !busy_q) begin
          frame_d   = build_payload(tx_data);
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        // Last inhibit cycle schedules the start bit, giving exactly one
        // cycle with both lines pulled before the clock is released.
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
        end
        if (cnt_q == INH_END) begin
          clk_oe_d  = 1'b0;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = SEND;
        end
      end

      SEND, WAIT_ACK, WAIT_IDLE: begin
        cnt_d = clk_fe ? '0 : cnt_q + 1'b1;
        if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else if (state_q == SEND) begin
          if (clk_fe) begin
            data_oe_d = ~frame_q[bit_idx_q];
            if (bit_idx_q == 4'd9) begin
              state_d = WAIT_ACK;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end else if (state_q == WAIT_ACK) begin
          if (clk_fe) begin
            if (!data_lvl) begin
              state_d = WAIT_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end else begin
          if (clk_lvl && data_lvl) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire        ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  wire        ps2_data_in = dev_data & ~ps2_data_oe;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit pulse_prev = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: bits the device should see after the start bit, LSB first.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = (($countones(b) % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Per-cycle rules: pulses exclusive and inside busy, everything clear the
  // cycle after a pulse, lines released whenever not busy.
  always @(negedge clk) begin
    if (rst) begin
      pulse_prev = 1'b0;
    end else begin
      if (pulse_prev) check("post_pulse_clear", 32'({tx_busy, tx_done, tx_err}), 0);
      if (tx_done || tx_err) begin
        check("pulse_exclusive", 32'(tx_done & tx_err), 0);
        check("pulse_in_busy", 32'(tx_busy), 1);
        done_cnt += int'(tx_done);
        err_cnt  += int'(tx_err);
      end
      if (!tx_busy) check("idle_released", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      pulse_prev = tx_done || tx_err;
    end
  end

  // Issues tx_start, measures the inhibit/start phase, then acts as the device.
  // clocks=0: device never clocks (timeout). inject_at/reset_at: clock pulse
  // index at which a busy tx_start or an asynchronous reset is applied.
  task automatic run_frame(input logic [7:0] b, input bit clocks, input bit ack,
                           input int inject_at, input int reset_at, output logic [9:0] rec);
    int inh, both, t;
    rec = '0;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_on_accept", 32'(tx_busy), 1);
    inh = 0;
    both = 0;
    for (int k = 0; k < 5000; k++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) both++;
      else break;
      @(negedge clk);
    end
    check("inhibit_len", 32'(inh), INH);
    check("start_req_len", 32'(both), 1);
    check("start_bit_held", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    if (!clocks) begin
      t = -1;
      for (int k = 1; k <= 4 * TMO; k++) begin
        @(negedge clk);
        if (tx_err) begin
          t = k;
          break;
        end
      end
      check("timeout_at", 32'(t), TMO);
      check("timeout_release", 32'({ps2_clk_oe, ps2_data_oe}), 0);
      return;
    end
    for (int i = 0; i < 11; i++) begin
      repeat (15) @(negedge clk);
      if (i == 10 && ack) dev_data = 1'b0;
      repeat (15) @(negedge clk);
      dev_clk = 1'b0;
      repeat (10) @(negedge clk);
      if (i == inject_at) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
      if (i == reset_at) begin
        check("busy_before_reset", 32'(tx_busy), 1);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        return;
      end
      repeat (20) @(negedge clk);
      if (i < 10) rec[i] = ps2_data_in;
      dev_clk = 1'b1;
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic settle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      if (!tx_busy) break;
      @(negedge clk);
    end
    check(name, 32'(k < 300), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic transact(input logic [7:0] b, input bit ack, input int inject_at,
                          output logic [9:0] rec);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(b, 1'b1, ack, inject_at, -1, rec);
    settle("settle_after_frame");
    check("frame_vs_model", 32'(rec), 32'(model_frame(b)));
    check("done_count", 32'(done_cnt - d0), ack ? 1 : 0);
    check("err_count", 32'(err_cnt - e0), ack ? 0 : 1);
  endtask

  initial begin
    logic [9:0] rec;
    logic [7:0] rb;
    bit         rack;
    int         d0, e0;

    repeat (3) @(negedge clk);
    check("reset_state", 32'({tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("model_pin_ED", 32'(model_frame(8'hED)), 32'h3ED);
    check("model_pin_F4", 32'(model_frame(8'hF4)), 32'h2F4);
    check("model_pin_00", 32'(model_frame(8'h00)), 32'h300);

    transact(CMD_SET_LEDS, 1'b1, -1, rec);
    check("frame_ED_literal", 32'(rec), 32'h3ED);

    transact(CMD_ENABLE, 1'b1, -1, rec);
    check("frame_F4_literal", 32'(rec), 32'h2F4);

    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(8'hA5, 1'b0, 1'b1, -1, -1, rec);
    settle("settle_after_timeout");
    check("timeout_err_count", 32'(err_cnt - e0), 1);
    check("timeout_done_count", 32'(done_cnt - d0), 0);

    transact(8'h5A, 1'b0, -1, rec);

    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(CMD_SET_LEDS, 1'b1, 1'b1, -1, 4, rec);
    repeat (5) @(negedge clk);
    check("after_reset_idle", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 0);
    check("after_reset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 0);
    transact(CMD_RESET, 1'b1, -1, rec);
    check("frame_FF_literal", 32'(rec), 32'h3FF);

    transact(CMD_SET_LEDS, 1'b1, 3, rec);
    check("busy_start_ignored", 32'(rec), 32'h3ED);

    for (int n = 0; n < 6; n++) begin
      rb   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      transact(rb, rack, -1, rec);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
